// File: rtl/neuron_core_mt_if.sv
// Pixel offer, result and configuration signals of the escape-time neuron core.
interface neuron_core_mt_if #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16,
  parameter int ID_W   = 16
);
  logic                     pixel_valid;
  logic                     pixel_ready;
  logic signed [WIDTH-1:0]  c_re;
  logic signed [WIDTH-1:0]  c_im;
  logic [ID_W-1:0]          pixel_id;
  logic [ITER_W-1:0]        max_iter;
  logic                     julia_en;
  logic signed [WIDTH-1:0]  julia_re;
  logic signed [WIDTH-1:0]  julia_im;
  logic signed [WIDTH-1:0]  escape_r2;
  logic                     result_valid;
  logic                     result_ready;
  logic [ID_W-1:0]          result_pixel_id;
  logic [ITER_W-1:0]        result_iter;
  logic                     result_escaped;
  logic                     busy;

  modport master (
    output pixel_valid, c_re, c_im, pixel_id, max_iter, julia_en,
           julia_re, julia_im, escape_r2, result_ready,
    input  pixel_ready, result_valid, result_pixel_id, result_iter,
           result_escaped, busy
  );

  modport slave (
    input  pixel_valid, c_re, c_im, pixel_id, max_iter, julia_en,
           julia_re, julia_im, escape_r2, result_ready,
    output pixel_ready, result_valid, result_pixel_id, result_iter,
           result_escaped, busy
  );
endinterface

// File: rtl/neuron_core_mt.sv
// Multi-context Mandelbrot/Julia escape-time core sharing one pipelined
// multiplier set among NCTX pixel contexts in a fixed round-robin slot order.
//
// ctx state | meaning
// CTX_FREE  | context empty, may be allocated to a new pixel
// CTX_RUN   | iterating; issued into the multipliers on its slot
// CTX_DONE  | finished, waiting to be presented on the result port

// Signed fixed-point multiply, three register stages.
module fixed_mul #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] p_o
);
  logic signed [WIDTH-1:0]   a_q, b_q, p_q;
  logic signed [2*WIDTH-1:0] prod_q;

  // operand capture, full-width product, rescale back to WIDTH (wrapping)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      p_q    <= '0;
    end else begin
      a_q    <= a_i;
      b_q    <= b_i;
      prod_q <= (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
      p_q    <= WIDTH'(prod_q >>> FRAC);
    end
  end

  assign p_o = p_q;
endmodule

module neuron_core_mt #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 28,
  parameter int ITER_W = 16,
  parameter int ID_W   = 16,
  parameter int NCTX   = 4
) (
  input logic             clk,
  input logic             rst_n,
  neuron_core_mt_if.slave bus
);
  localparam int CW = $clog2(NCTX);

  typedef enum logic [1:0] {CTX_FREE, CTX_RUN, CTX_DONE} ctx_state_e;

  ctx_state_e              st_q [NCTX], st_d [NCTX];
  logic signed [WIDTH-1:0] zr_q [NCTX], zr_d [NCTX];
  logic signed [WIDTH-1:0] zi_q [NCTX], zi_d [NCTX];
  logic signed [WIDTH-1:0] cr_q [NCTX], cr_d [NCTX];
  logic signed [WIDTH-1:0] ci_q [NCTX], ci_d [NCTX];
  logic [ID_W-1:0]         id_q [NCTX], id_d [NCTX];
  logic [ITER_W-1:0]       it_q [NCTX], it_d [NCTX];
  logic                    esc_q [NCTX], esc_d [NCTX];

  logic [CW-1:0]           slot_q;
  logic [2:0]              pv_q;
  logic [CW-1:0]           pc_q [3];

  logic                    rv_q, rv_d;
  logic [CW-1:0]           last_q, last_d;
  logic [ID_W-1:0]         rid_q, rid_d;
  logic [ITER_W-1:0]       rit_q, rit_d;
  logic                    resc_q, resc_d;

  logic signed [WIDTH-1:0] zr2, zi2, zri, mag;
  logic [CW-1:0]           chk_idx, alloc_idx, pick_idx, cand;
  logic                    alloc_hit, pick_hit, any_used, escaped, stop;
  logic [2:0]              zr_top, zi_top;

  fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_rr (
    .clk(clk), .rst_n(rst_n), .a_i(zr_q[slot_q]), .b_i(zr_q[slot_q]), .p_o(zr2));
  fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ii (
    .clk(clk), .rst_n(rst_n), .a_i(zi_q[slot_q]), .b_i(zi_q[slot_q]), .p_o(zi2));
  fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ri (
    .clk(clk), .rst_n(rst_n), .a_i(zr_q[slot_q]), .b_i(zi_q[slot_q]), .p_o(zri));

  // lowest free context for allocation, round-robin DONE pick after last emitted
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    pick_hit  = 1'b0;
    pick_idx  = '0;
    cand      = '0;
    any_used  = 1'b0;
    for (int i = NCTX - 1; i >= 0; i--) begin
      if (st_q[i] == CTX_FREE) begin
        alloc_hit = 1'b1;
        alloc_idx = CW'(i);
      end else begin
        any_used = 1'b1;
      end
    end
    for (int i = NCTX; i >= 1; i--) begin
      cand = last_q + CW'(i);
      if (st_q[cand] == CTX_DONE) begin
        pick_hit = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // escape test for the context whose products emerge this cycle
  always_comb begin
    chk_idx = pc_q[2];
    mag     = zr2 + zi2;
    zr_top  = zr_q[chk_idx][WIDTH-1 -: 3];
    zi_top  = zi_q[chk_idx][WIDTH-1 -: 3];
    escaped = mag[WIDTH-1] || (mag >= bus.escape_r2)
              || !(zr_top == 3'b000 || zr_top == 3'b111)
              || !(zi_top == 3'b000 || zi_top == 3'b111);
    stop    = escaped || (it_q[chk_idx] >= bus.max_iter);
  end

  // context next state: allocate, check/update, release on result accept
  always_comb begin
    st_d   = st_q;
    zr_d   = zr_q;
    zi_d   = zi_q;
    cr_d   = cr_q;
    ci_d   = ci_q;
    id_d   = id_q;
    it_d   = it_q;
    esc_d  = esc_q;
    rv_d   = rv_q;
    last_d = last_q;
    rid_d  = rid_q;
    rit_d  = rit_q;
    resc_d = resc_q;

    if (bus.pixel_valid && alloc_hit) begin
      st_d[alloc_idx]  = CTX_RUN;
      it_d[alloc_idx]  = '0;
      id_d[alloc_idx]  = bus.pixel_id;
      esc_d[alloc_idx] = 1'b0;
      if (bus.julia_en) begin
        zr_d[alloc_idx] = bus.c_re;
        zi_d[alloc_idx] = bus.c_im;
        cr_d[alloc_idx] = bus.julia_re;
        ci_d[alloc_idx] = bus.julia_im;
      end else begin
        zr_d[alloc_idx] = '0;
        zi_d[alloc_idx] = '0;
        cr_d[alloc_idx] = bus.c_re;
        ci_d[alloc_idx] = bus.c_im;
      end
    end

    if (pv_q[2]) begin
      if (stop) begin
        st_d[chk_idx]  = CTX_DONE;
        esc_d[chk_idx] = escaped;
      end else begin
        zr_d[chk_idx] = zr2 - zi2 + cr_q[chk_idx];
        zi_d[chk_idx] = (zri <<< 1) + ci_q[chk_idx];
        it_d[chk_idx] = it_q[chk_idx] + ITER_W'(1);
      end
    end

    // one-cycle bubble after an accept keeps the freed context out of the pick
    if (rv_q) begin
      if (bus.result_ready) begin
        rv_d         = 1'b0;
        st_d[last_q] = CTX_FREE;
      end
    end else if (pick_hit) begin
      rv_d   = 1'b1;
      last_d = pick_idx;
      rid_d  = id_q[pick_idx];
      rit_d  = it_q[pick_idx];
      resc_d = esc_q[pick_idx];
    end
  end

  // state registers, slot pointer and issue tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCTX; i++) begin
        st_q[i]  <= CTX_FREE;
        zr_q[i]  <= '0;
        zi_q[i]  <= '0;
        cr_q[i]  <= '0;
        ci_q[i]  <= '0;
        id_q[i]  <= '0;
        it_q[i]  <= '0;
        esc_q[i] <= 1'b0;
      end
      slot_q <= '0;
      pv_q   <= '0;
      for (int i = 0; i < 3; i++) pc_q[i] <= '0;
      rv_q   <= 1'b0;
      last_q <= CW'(NCTX - 1);
      rid_q  <= '0;
      rit_q  <= '0;
      resc_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      id_q    <= id_d;
      it_q    <= it_d;
      esc_q   <= esc_d;
      slot_q  <= slot_q + CW'(1);
      pv_q    <= {pv_q[1:0], st_q[slot_q] == CTX_RUN};
      pc_q[0] <= slot_q;
      pc_q[1] <= pc_q[0];
      pc_q[2] <= pc_q[1];
      rv_q    <= rv_d;
      last_q  <= last_d;
      rid_q   <= rid_d;
      rit_q   <= rit_d;
      resc_q  <= resc_d;
    end
  end

  assign bus.pixel_ready     = alloc_hit;
  assign bus.busy            = any_used || rv_q;
  assign bus.result_valid    = rv_q;
  assign bus.result_pixel_id = rid_q;
  assign bus.result_iter     = rit_q;
  assign bus.result_escaped  = resc_q;
endmodule

// File: tb/tb_neuron_core_mt.sv
// Directed bench for neuron_core_mt: single-pixel vector table plus
// back-to-back fill, output backpressure and mid-run reset sequences.
module tb_neuron_core_mt;
  localparam int NCTX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  neuron_core_mt_if #(.WIDTH(32), .ITER_W(16), .ID_W(16)) bus ();

  neuron_core_mt #(.WIDTH(32), .FRAC(28), .ITER_W(16), .ID_W(16), .NCTX(NCTX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        jen;
    logic [31:0] cre, cim, jre, jim, r2;
    logic [15:0] maxit, id, exp_iter;
    logic        exp_esc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic jen, input logic [31:0] cre, cim, jre, jim,
                            input logic [15:0] id);
    bit done = 0;
    bus.julia_en = jen;
    bus.c_re = cre;  bus.c_im = cim;
    bus.julia_re = jre;  bus.julia_im = jim;
    bus.pixel_id = id;
    bus.pixel_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (bus.pixel_ready) done = 1;
      tick();
    end
    bus.pixel_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: id %0h not accepted", id);
    end
  endtask

  task automatic wait_result(output logic [15:0] id, output logic [15:0] it, output logic esc);
    bit done = 0;
    id = '0; it = '0; esc = 1'b0;
    bus.result_ready = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (bus.result_valid) begin
        id = bus.result_pixel_id;
        it = bus.result_iter;
        esc = bus.result_escaped;
        done = 1;
      end
      tick();
    end
    bus.result_ready = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL result_timeout: no result within budget");
    end
  endtask

  initial begin
    logic [15:0] rid, rit, hid, hit;
    logic        resc, hesc;
    int          cnt [NCTX];
    int          bad;

    //           jen   c_re          c_im          j_re   j_im   r2            max  id        iter esc
    vecs[0] = '{1'b0, 32'h3000_0000, 32'h0,       32'h0, 32'h0, 32'h4000_0000, 100, 16'h100, 1,   1'b1};
    vecs[1] = '{1'b0, 32'h0,         32'h0,       32'h0, 32'h0, 32'h4000_0000, 100, 16'h101, 100, 1'b0};
    vecs[2] = '{1'b1, 32'h1800_0000, 32'h0,       32'h0, 32'h0, 32'h4000_0000, 100, 16'h102, 1,   1'b1};
    vecs[3] = '{1'b1, 32'h0800_0000, 32'h0,       32'h0, 32'h0, 32'h4000_0000, 50,  16'h103, 50,  1'b0};
    vecs[4] = '{1'b0, 32'h0,         32'h0,       32'h0, 32'h0, 32'h4000_0000, 0,   16'h104, 0,   1'b0};
    vecs[5] = '{1'b0, 32'hE000_0000, 32'h0,       32'h0, 32'h0, 32'h4000_0000, 100, 16'h105, 1,   1'b1};
    vecs[6] = '{1'b0, 32'h0, 32'h1000_0000,       32'h0, 32'h0, 32'h4000_0000, 10,  16'h106, 10,  1'b0};
    vecs[7] = '{1'b0, 32'h1000_0000, 32'h0,       32'h0, 32'h0, 32'h1000_0000, 100, 16'h107, 1,   1'b1};
    vecs[8] = '{1'b0, 32'h0,         32'h0,       32'h0, 32'h0, 32'h0,         100, 16'h108, 0,   1'b1};
    vecs[9] = '{1'b0, 32'h1000_0000, 32'h0,       32'h0, 32'h0, 32'h4000_0000, 100, 16'h109, 2,   1'b1};

    bus.pixel_valid = 1'b0;  bus.result_ready = 1'b0;
    bus.c_re = '0;  bus.c_im = '0;  bus.pixel_id = '0;
    bus.max_iter = 16'd100;  bus.julia_en = 1'b0;
    bus.julia_re = '0;  bus.julia_im = '0;
    bus.escape_r2 = 32'h4000_0000;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_pixel_ready", bus.pixel_ready, 1);
    chk("reset_result_valid", bus.result_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_result_iter", bus.result_iter, 0);

    for (int v = 0; v < 10; v++) begin
      bus.max_iter = vecs[v].maxit;
      bus.escape_r2 = vecs[v].r2;
      send_pixel(vecs[v].jen, vecs[v].cre, vecs[v].cim, vecs[v].jre, vecs[v].jim, vecs[v].id);
      wait_result(rid, rit, resc);
      chk($sformatf("vec%0d_id", v), rid, vecs[v].id);
      chk($sformatf("vec%0d_iter", v), rit, vecs[v].exp_iter);
      chk($sformatf("vec%0d_escaped", v), resc, vecs[v].exp_esc);
    end
    tick();
    chk("idle_busy", bus.busy, 0);

    // back-to-back fill of every context
    bus.max_iter = 16'd20;
    bus.escape_r2 = 32'h4000_0000;
    for (int k = 0; k < NCTX; k++) begin
      cnt[k] = 0;
      send_pixel(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h200 + 16'(k));
    end
    chk("fill_pixel_ready", bus.pixel_ready, 0);
    chk("fill_busy", bus.busy, 1);
    for (int k = 0; k < NCTX; k++) begin
      wait_result(rid, rit, resc);
      chk($sformatf("fill%0d_iter", k), rit, 20);
      chk($sformatf("fill%0d_escaped", k), resc, 0);
      if (rid >= 16'h200 && rid < 16'h200 + 16'(NCTX)) cnt[rid - 16'h200]++;
    end
    for (int k = 0; k < NCTX; k++) chk($sformatf("fill_id%0d_count", k), cnt[k], 1);

    // output backpressure with two finished pixels
    bus.max_iter = 16'd100;
    bus.result_ready = 1'b0;
    send_pixel(1'b0, 32'h3000_0000, 32'h0, 32'h0, 32'h0, 16'h300);
    send_pixel(1'b0, 32'h3000_0000, 32'h0, 32'h0, 32'h0, 16'h301);
    bad = 1;
    for (int k = 0; k < 500 && bad != 0; k++) begin
      if (bus.result_valid) bad = 0;
      else tick();
    end
    chk("hold_valid_seen", bus.result_valid, 1);
    hid = bus.result_pixel_id;  hit = bus.result_iter;  hesc = bus.result_escaped;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!bus.result_valid || bus.result_pixel_id !== hid ||
          bus.result_iter !== hit || bus.result_escaped !== hesc) bad++;
    end
    chk("hold_stable_cycles", bad, 0);
    chk("hold_iter", hit, 1);
    chk("hold_escaped", hesc, 1);
    chk("hold_id_valid", (hid == 16'h300 || hid == 16'h301), 1);
    wait_result(rid, rit, resc);
    chk("hold_first_id", rid, hid);
    wait_result(rid, rit, resc);
    chk("hold_second_id", rid, (hid == 16'h300) ? 16'h301 : 16'h300);
    chk("hold_second_iter", rit, 1);

    // reset with three contexts running
    bus.max_iter = 16'd1000;
    for (int k = 0; k < 3; k++) send_pixel(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h400 + 16'(k));
    repeat (20) tick();
    chk("prerst_busy", bus.busy, 1);
    chk("prerst_pixel_ready", bus.pixel_ready, 1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_pixel_ready", bus.pixel_ready, 1);
    chk("postrst_busy", bus.busy, 0);
    bus.result_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus.result_valid) bad++;
      tick();
    end
    bus.result_ready = 1'b0;
    chk("postrst_no_results", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/neuron_core_mt.md
NEURON_CORE_MT -- requirements
Module: neuron_core_mt

Interface
REQ-001 SHALL have parameter WIDTH, default 32, fixed-point word width (signed, two's complement).
REQ-002 SHALL have parameter FRAC, default 28, fractional bits.
REQ-003 SHALL have parameter ITER_W, default 16, iteration counter width.
REQ-004 SHALL have parameter ID_W, default 16, pixel id width.
REQ-005 SHALL have parameter NCTX, default 4, number of pixel contexts; power of two, >= 4.
REQ-006 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port pixel_valid  input  1  pixel offer.
REQ-009 SHALL have port pixel_ready  output  1  a context is free.
REQ-010 SHALL have ports c_re, c_im  input  WIDTH  pixel coordinate.
REQ-011 SHALL have port pixel_id  input  ID_W  pixel tag.
REQ-012 SHALL have port max_iter  input  ITER_W  iteration limit.
REQ-013 SHALL have port julia_en  input  1  0 = Mandelbrot, 1 = Julia.
REQ-014 SHALL have ports julia_re, julia_im  input  WIDTH  Julia constant.
REQ-015 SHALL have port escape_r2  input  WIDTH  squared escape radius (4.0 = 32'h4000_0000 at defaults).
REQ-016 SHALL have port result_valid  output  1  result offer.
REQ-017 SHALL have port result_ready  input  1  result sink ready.
REQ-018 SHALL have ports result_pixel_id (ID_W), result_iter (ITER_W), result_escaped (1)  output  result payload.
REQ-019 SHALL have port busy  output  1  any context occupied or result pending.

Function
REQ-020 SHALL hold NCTX contexts, each FREE, RUN or DONE, with registers z_re, z_im, c_re, c_im, id, iter.
REQ-021 SHALL share one set of three fixed_mul instances (z_re², z_im², z_re*z_im; 3-cycle latency) among contexts via a free-running slot pointer modulo NCTX.
REQ-022 SHALL issue the context at the pointer into the multipliers only if it is RUN; the check/update for that context SHALL occur 3 cycles after issue, before its next turn (NCTX cycles later).
REQ-023 SHALL accept a pixel when pixel_valid && pixel_ready, writing it into the lowest-indexed FREE context and setting it to RUN with iter = 0.
REQ-024 SHALL, on accept, load z = 0 and c = (c_re, c_im) when julia_en = 0; z = (c_re, c_im) and c = (julia_re, julia_im) sampled that cycle when julia_en = 1.
REQ-025 SHALL, at check: mag = z_re² + z_im²; escaped = mag sign bit set, or mag >= escape_r2 (signed compare), or either z component's top three bits not all equal.
REQ-026 SHALL, at check, set the context to DONE with result_escaped = escaped if escaped or iter >= max_iter; otherwise set z_re = z_re² − z_im² + c_re and z_im = (z_re*z_im << 1) + c_im (truncated to WIDTH, wrap), and iter += 1.
REQ-027 SHALL use the current max_iter and escape_r2 at every check; changing them mid-pixel is legal.
REQ-028 SHALL present one DONE context at a time in a registered output stage, selected round-robin starting after the last one emitted; payload SHALL stay stable while result_valid && !result_ready.
REQ-029 SHALL free a context on the cycle its result is accepted; it SHALL become allocatable the following cycle (no same-cycle reuse).
REQ-030 SHALL assert pixel_ready iff at least one context is FREE (registered state); busy = any non-FREE context or result_valid.
REQ-031 SHALL keep DONE contexts from issuing; backpressure SHALL never drop or corrupt a result.
REQ-032 SHALL, with max_iter = 0, produce result_iter = 0 at the first check.

Reset
REQ-033 SHALL on rst_n low set all contexts FREE, slot pointer 0, all z/c/iter/id registers 0, result_valid 0, result payload 0, busy 0; pixel_ready = 1 after release.
REQ-034 SHALL discard in-flight pixels and multiplier results on reset mid-operation, with no result emitted for them.

Verification
REQ-035 SHALL cover: reset release -> pixel_ready=1, result_valid=0, busy=0.
REQ-036 SHALL cover: Mandelbrot c=(0x3000_0000,0), max_iter=100 -> result_iter=1, escaped=1; c=(0,0), max_iter=100 -> result_iter=100, escaped=0.
REQ-037 SHALL cover: NCTX back-to-back pixels with c=0 and max_iter=20 -> pixel_ready low after NCTX-th accept, NCTX results each iter=20, all ids returned exactly once.
REQ-038 SHALL cover: result_ready held 0 for 50 cycles with 2 pixels done -> result_valid held, payload stable, both results delivered after release.
REQ-039 SHALL cover: julia_en=1, constant (0,0), z0=(0x1800_0000,0) -> iter=1, escaped=1; z0=(0x0800_0000,0), max_iter=50 -> iter=50, escaped=0.
REQ-040 SHALL cover: rst_n pulsed with 3 contexts RUN -> no results emitted afterwards, pixel_ready=1 next cycle after release.
